// File: rtl/if_id_pipeline.sv
// if_id_pipeline: IF->ID pipeline register built as a 2-entry skid buffer.
// The main entry drives decode; the skid entry absorbs the one beat that
// fetch can still push in the cycle decode stalls, so in_ready is a plain
// register. Flush (redirect) and reset discard all held beats. Invalid
// outputs are masked to NOP_WORD / 0.
// Optional build macro IF_ID_PERF_EN adds saturating stall/bubble/flush
// performance counters; without it the core is unchanged.
module if_id_pipeline #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_npc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
`ifdef IF_ID_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [DATA_W-1:0] out_npc
);

  // Occupancy encoded as {m_valid, s_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  logic              r_m_valid;
  logic              r_s_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_m_instr;
  logic [DATA_W-1:0] r_m_npc;
  logic [DATA_W-1:0] r_s_instr;
  logic [DATA_W-1:0] r_s_npc;

  logic   w_push;
  logic   w_pop;
  logic   w_load_main_in;
  logic   w_load_main_skid;
  logic   w_load_skid;
  state_t w_state;

  assign w_state = state_t'({r_m_valid, r_s_valid});
  assign w_push  = in_valid & r_in_ready;
  assign w_pop   = r_m_valid & out_ready;

  // Data-path enables: skid drains into main on a pop from FULL; otherwise a
  // pushed beat goes to main when main is free (or leaving), else to skid.
  assign w_load_main_skid = r_s_valid & w_pop;
  assign w_load_main_in   = w_push & ~r_s_valid & (~r_m_valid | w_pop);
  assign w_load_skid      = w_push & r_m_valid & ~r_s_valid & ~w_pop;

  // Control state: occupancy flags and registered in_ready; reset/flush win.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_m_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            r_s_valid  <= 1'b1;
            r_in_ready <= 1'b0;
          end else if (w_pop && !w_push) begin
            r_m_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean empty buffer.
          r_m_valid  <= 1'b0;
          r_s_valid  <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Main data entry: loads only on its move/push enables, never reset.
  always_ff @(posedge clk) begin
    if (w_load_main_skid) begin
      r_m_instr <= r_s_instr;
      r_m_npc   <= r_s_npc;
    end else if (w_load_main_in) begin
      r_m_instr <= in_instr;
      r_m_npc   <= in_npc;
    end
  end

  // Skid data entry: captures the beat accepted while decode is stalled.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_s_instr <= in_instr;
      r_s_npc   <= in_npc;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  assign out_instr = r_m_valid ? r_m_instr : NOP_WORD;
  assign out_npc   = r_m_valid ? r_m_npc   : '0;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  logic [15:0] r_flush_cnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Performance counters: saturating, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (in_valid && !r_in_ready) begin
        r_stall_cnt <= sat_inc32(r_stall_cnt);
      end
      if (out_ready && !r_m_valid) begin
        r_bubble_cnt <= sat_inc32(r_bubble_cnt);
      end
      if (flush) begin
        r_flush_cnt <= sat_inc16(r_flush_cnt);
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule
